sid_dca_pipe: RTL and testbench

- Registered voice DCA (digitally controlled amplifier) datapath for the SID voice.
- Converts a 12-bit waveform and an 8-bit envelope to amplitudes. For MOS6581 it uses the non-linear R-2R ladder DAC model; for MOS8580 it uses straight binary.
- Computes out = voice_dc + (wave_amp + wave_dc) * env_amp, or the subtracted form, in a 2-stage pipeline.
- Sits between the waveform/envelope generators and the voice mixer; one result per active cycle.

---
 rtl/sid_dca_pipe_pkg.sv | 18 +
 rtl/sid_dca_pipe_dac.sv | 83 ++++++++
 rtl/sid_dca_pipe.sv | 95 +++++++++
 tb/tb_sid_dca_pipe.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sid_dca_pipe_pkg.sv
// Shared SID voice types and DC constants used by the DCA datapath and its users.
package sid;
    typedef enum logic {
        MOS6581 = 1'b0,
        MOS8580 = 1'b1
    } model_e;

    typedef logic [7:0]         reg8_t;
    typedef logic [11:0]        reg12_t;
    typedef logic signed [15:0] s16_t;
    typedef logic signed [21:0] s22_t;
    typedef logic signed [31:0] s32_t;

    localparam s16_t WAVEFORM_DC_6581 = -16'sh380;
    localparam s16_t WAVEFORM_DC_8580 = -16'sh800;
    localparam s32_t VOICE_DC_6581    = 32'sh800 * 32'shff;
    localparam s32_t VOICE_DC_8580    = 32'sh0;
endpackage

// File: rtl/sid_dca_pipe_dac.sv
// MOS6581 R-2R ladder DAC: per-bit weights come from the ladder network at
// elaboration time; the code is mapped by summing the weights of its set bits.
module r2r_ladder_dac #(
    parameter int BITS           = 12,
    parameter int R2R_RATIO_X100 = 220,
    parameter int FRAC_BITS      = 16
) (
    input  logic [BITS-1:0] code,
    output logic [BITS-1:0] amp
);
    localparam int WW    = BITS + FRAC_BITS;
    localparam int AW    = WW + 4;
    localparam int VFRAC = 30;
    localparam int RFRAC = 20;

    // Output voltage with only bit s driven; bit 0 has no termination resistor.
    function automatic longint ladder_v(int s);
        longint r, r2, rn, rpar, rsum, vn;
        bit     open_tail;
        r         = longint'(100) <<< RFRAC;
        r2        = longint'(R2R_RATIO_X100) <<< RFRAC;
        vn        = longint'(1) <<< VFRAC;
        rn        = 0;
        rpar      = 0;
        open_tail = 1'b1;
        for (int b = 0; b < s; b++) begin
            if (open_tail) begin
                rn        = r + r2;
                open_tail = 1'b0;
            end else begin
                rn = r + (r2 * rn) / (r2 + rn);
            end
        end
        if (open_tail) begin
            rn = r2;
        end else begin
            rpar = (r2 * rn) / (r2 + rn);
            vn   = (vn * rpar) / r2;
            rn   = rpar;
        end
        for (int b = s + 1; b < BITS; b++) begin
            rsum = rn + r;
            rpar = (r2 * rsum) / (r2 + rsum);
            vn   = (vn * rpar) / rsum;
            rn   = rpar;
        end
        return vn;
    endfunction

    // Weights scaled so that they sum to 2^BITS-1, with FRAC_BITS fraction bits.
    function automatic logic [BITS*WW-1:0] calc_weights();
        logic [BITS*WW-1:0] w;
        longint             total;
        longint             scaled;
        total = 0;
        for (int i = 0; i < BITS; i++) total += ladder_v(i);
        w = '0;
        for (int i = 0; i < BITS; i++) begin
            scaled = ((ladder_v(i) * ((longint'(1) <<< BITS) - 1)) <<< FRAC_BITS) + total / 2;
            w[i*WW +: WW] = WW'(scaled / total);
        end
        return w;
    endfunction

    localparam logic [BITS*WW-1:0] WEIGHTS = calc_weights();

    function automatic logic [BITS-1:0] round_sat(logic [AW-1:0] acc);
        logic [AW-1:0] rounded;
        rounded = (acc + (AW'(1) << (FRAC_BITS - 1))) >> FRAC_BITS;
        if (rounded > AW'((1 << BITS) - 1)) return '1;
        return rounded[BITS-1:0];
    endfunction

    logic [AW-1:0] acc;

    always_comb begin
        acc = '0;
        for (int i = 0; i < BITS; i++) begin
            if (code[i]) acc = acc + AW'(WEIGHTS[i*WW +: WW]);
        end
        amp = round_sat(acc);
    end
endmodule

// File: rtl/sid_dca_pipe.sv
// SID voice DCA: two-stage registered DAC lookup followed by the
// voice_dc +/- (wave_amp + wave_dc) * env_amp multiply-accumulate.
module sid_dca_pipe
    import sid::*;
#(
    parameter int WAVE_BITS      = 12,
    parameter int ENV_BITS       = 8,
    parameter int R2R_RATIO_X100 = 220,
    parameter int FRAC_BITS      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    active,
    input  logic                    model,
    input  logic [WAVE_BITS-1:0]    wave,
    input  logic [ENV_BITS-1:0]     env,
    input  logic signed [15:0]      wave_dc,
    input  logic signed [31:0]      voice_dc,
    input  logic                    sub,
    output logic [WAVE_BITS-1:0]    wave_amp,
    output logic signed [21:0]      dca_o
);
    logic [WAVE_BITS-1:0] wave_dac;
    logic [ENV_BITS-1:0]  env_dac;

    r2r_ladder_dac #(
        .BITS           (WAVE_BITS),
        .R2R_RATIO_X100 (R2R_RATIO_X100),
        .FRAC_BITS      (FRAC_BITS)
    ) u_wave_dac (
        .code (wave),
        .amp  (wave_dac)
    );

    r2r_ladder_dac #(
        .BITS           (ENV_BITS),
        .R2R_RATIO_X100 (R2R_RATIO_X100),
        .FRAC_BITS      (FRAC_BITS)
    ) u_env_dac (
        .code (env),
        .amp  (env_dac)
    );

    logic [WAVE_BITS-1:0] wave_amp_p1;
    logic [ENV_BITS-1:0]  env_p1;
    s16_t                 wave_dc_p1;
    s32_t                 voice_dc_p1;
    logic                 sub_p1;
    s22_t                 dca_p2;

    // Stage 1: DAC model selection, operands registered with their sample
    always_ff @(posedge clk) begin
        if (rst) begin
            wave_amp_p1 <= '0;
            env_p1      <= '0;
            wave_dc_p1  <= '0;
            voice_dc_p1 <= '0;
            sub_p1      <= 1'b0;
        end else if (active) begin
            wave_amp_p1 <= (model_e'(model) == MOS6581) ? wave_dac : wave;
            env_p1      <= (model_e'(model) == MOS6581) ? env_dac : env;
            wave_dc_p1  <= wave_dc;
            voice_dc_p1 <= voice_dc;
            sub_p1      <= sub;
        end
    end

    s16_t       a;
    s16_t       b;
    s32_t       prod;
    s32_t       sum;
    logic [9:0] sum_hi_unused;

    always_comb begin
        a    = s16_t'(16'(wave_amp_p1)) + wave_dc_p1;
        b    = s16_t'(16'(env_p1));
        prod = s32_t'(a) * s32_t'(b);
        sum  = sub_p1 ? (voice_dc_p1 - prod) : (voice_dc_p1 + prod);
    end

    // The sum wraps; only the low 22 bits leave the block.
    assign sum_hi_unused = sum[31:22];

    // Stage 2: multiply-accumulate result
    always_ff @(posedge clk) begin
        if (rst) begin
            dca_p2 <= '0;
        end else if (active) begin
            dca_p2 <= sum[21:0];
        end
    end

    assign wave_amp = wave_amp_p1;
    assign dca_o    = dca_p2;
endmodule

// File: tb/tb_sid_dca_pipe.sv
// Directed bench for sid_dca_pipe with a floating-point golden ladder model.
module tb_sid_dca_pipe;
    import sid::*;

    localparam int R2R = 220;

    logic               clk = 1'b0;
    logic               rst;
    logic               active;
    logic               model;
    reg12_t             wave;
    reg8_t              env;
    s16_t               wave_dc;
    s32_t               voice_dc;
    logic               sub;
    logic [11:0]        wave_amp;
    logic signed [21:0] dca_o;

    int  n_cmp = 0;
    int  n_err = 0;
    real w12 [12];
    real w8  [8];

    sid_dca_pipe #(
        .WAVE_BITS      (12),
        .ENV_BITS       (8),
        .R2R_RATIO_X100 (R2R),
        .FRAC_BITS      (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .active   (active),
        .model    (model),
        .wave     (wave),
        .env      (env),
        .wave_dc  (wave_dc),
        .voice_dc (voice_dc),
        .sub      (sub),
        .wave_amp (wave_amp),
        .dca_o    (dca_o)
    );

    always #5 clk = ~clk;

    function automatic real ladder_real(int bits, int s);
        real r, r2, rn, vn, cur;
        bit  open_tail;
        r = 1.0;
        r2 = real'(R2R) / 100.0;
        vn = 1.0;
        rn = 0.0;
        open_tail = 1'b1;
        for (int k = 0; k < s; k++) begin
            if (open_tail) begin
                rn = r + r2;
                open_tail = 1'b0;
            end else begin
                rn = r + r2 * rn / (r2 + rn);
            end
        end
        if (open_tail) begin
            rn = r2;
        end else begin
            rn = r2 * rn / (r2 + rn);
            vn = vn * rn / r2;
        end
        for (int k = s + 1; k < bits; k++) begin
            rn = rn + r;
            cur = vn / rn;
            rn = r2 * rn / (r2 + rn);
            vn = rn * cur;
        end
        return vn;
    endfunction

    task automatic build_weights();
        real t12, t8;
        t12 = 0.0;
        t8 = 0.0;
        for (int j = 0; j < 12; j++) t12 += ladder_real(12, j);
        for (int j = 0; j < 8; j++) t8 += ladder_real(8, j);
        for (int j = 0; j < 12; j++) w12[j] = ladder_real(12, j) * 4095.0 / t12;
        for (int j = 0; j < 8; j++) w8[j] = ladder_real(8, j) * 255.0 / t8;
    endtask

    // Rounded golden code; when the exact value sits on a .5 boundary either
    // neighbour is accepted, since fixed-point weights may legitimately tip it.
    function automatic int gold_dac(int bits, int x, int obs);
        real g, fr;
        int  lo, ex, alt, top;
        g = 0.0;
        for (int j = 0; j < bits; j++) begin
            if (x[j]) g += (bits == 12) ? w12[j] : w8[j % 8];
        end
        lo = $rtoi($floor(g));
        fr = g - $floor(g);
        ex = (fr >= 0.5) ? lo + 1 : lo;
        alt = (fr >= 0.5) ? lo : lo + 1;
        if (fr > 0.499 && fr < 0.501 && obs == alt) ex = alt;
        top = (1 << bits) - 1;
        if (ex > top) ex = top;
        return ex;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic m, input reg12_t w, input reg8_t e,
                         input s16_t wdc, input s32_t vdc, input logic s);
        model = m;
        wave = w;
        env = e;
        wave_dc = wdc;
        voice_dc = vdc;
        sub = s;
    endtask

    task automatic chk(input string tag, input logic [21:0] obs, input logic [21:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        int g;
        build_weights();
        rst = 1'b1;
        active = 1'b1;
        drive(MOS8580, 12'h0, 8'h0, 16'sh0, 32'sh0, 1'b0);
        step();
        step();
        chk("reset_wave_amp", 22'(wave_amp), 22'h0);
        chk("reset_dca", dca_o, 22'h0);
        rst = 1'b0;

        // 8580 full scale
        drive(MOS8580, 12'hFFF, 8'hFF, WAVEFORM_DC_8580, VOICE_DC_8580, 1'b0);
        step();
        chk("t1_wave_amp", 22'(wave_amp), 22'hFFF);
        step();
        chk("t1_dca", dca_o, 22'h07F701);

        // 8580 back-to-back: zero amplitude, then subtracted product
        drive(MOS8580, 12'h800, 8'h80, WAVEFORM_DC_8580, 32'sh7F800, 1'b0);
        step();
        drive(MOS8580, 12'hFFF, 8'hFF, WAVEFORM_DC_8580, 32'sh7F800, 1'b1);
        step();
        chk("t2_dca_zero_amp", dca_o, 22'h07F800);
        step();
        chk("t2_dca_sub", dca_o, 22'h0000FF);

        // 6581 full scale: 0x7F800 + 0xC7F*0xFF = 0x146A81
        drive(MOS6581, 12'hFFF, 8'hFF, WAVEFORM_DC_6581, VOICE_DC_6581, 1'b0);
        step();
        chk("t4_wave_amp", 22'(wave_amp), 22'hFFF);
        step();
        chk("t4_dca", dca_o, 22'h146A81);

        // 6581 negative result: -0x380*0xFF wraps to 0x3C8380
        drive(MOS6581, 12'h000, 8'hFF, WAVEFORM_DC_6581, 32'sh0, 1'b0);
        step();
        chk("neg_wave_amp", 22'(wave_amp), 22'h0);
        step();
        chk("neg_dca", dca_o, 22'h3C8380);

        // 6581 mid code is not binary; env DAC exercised via the product
        drive(MOS6581, 12'h800, 8'h00, WAVEFORM_DC_6581, 32'sh0, 1'b0);
        step();
        n_cmp++;
        assert (wave_amp !== 12'h800)
        else begin
            n_err++;
            $error("FAIL dac12_mid_nonbinary: observed %h expected not 800", wave_amp);
        end
        chk("dac12_mid_gold", 22'(wave_amp), 22'(gold_dac(12, 'h800, int'(wave_amp))));
        drive(MOS6581, 12'hFFF, 8'h80, WAVEFORM_DC_6581, 32'sh0, 1'b0);
        step();
        step();
        g = gold_dac(8, 'h80, -1);
        chk("dac8_env_dca", dca_o, 22'(3199 * g));

        // Upper bits of the 32-bit sum are dropped
        drive(MOS8580, 12'h800, 8'h55, WAVEFORM_DC_8580, 32'sh12345678, 1'b0);
        step();
        step();
        chk("wrap_dca", dca_o, 22'h345678);

        // Model switch between consecutive samples
        drive(MOS6581, 12'h800, 8'h01, WAVEFORM_DC_6581, 32'sh0, 1'b0);
        step();
        chk("switch_6581", 22'(wave_amp), 22'(gold_dac(12, 'h800, int'(wave_amp))));
        drive(MOS8580, 12'h800, 8'h01, WAVEFORM_DC_8580, 32'sh0, 1'b0);
        step();
        chk("switch_8580", 22'(wave_amp), 22'h800);

        // Full 6581 waveform DAC sweep
        for (int c = 0; c < 4096; c++) begin
            drive(MOS6581, 12'(c), 8'h00, WAVEFORM_DC_6581, 32'sh0, 1'b0);
            step();
            chk($sformatf("dac12[%03h]", c), 22'(wave_amp), 22'(gold_dac(12, c, int'(wave_amp))));
        end

        // Freeze with active low, then resume
        drive(MOS8580, 12'h800, 8'h00, WAVEFORM_DC_8580, 32'sh1234, 1'b0);
        step();
        drive(MOS8580, 12'hFFF, 8'hFF, WAVEFORM_DC_8580, 32'sh0, 1'b0);
        step();
        chk("pre_freeze_dca", dca_o, 22'h001234);
        active = 1'b0;
        drive(MOS8580, 12'h900, 8'h10, WAVEFORM_DC_8580, 32'sh0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("freeze%0d_wave_amp", k), 22'(wave_amp), 22'hFFF);
            chk($sformatf("freeze%0d_dca", k), dca_o, 22'h001234);
        end
        active = 1'b1;
        step();
        chk("resume1_wave_amp", 22'(wave_amp), 22'h900);
        chk("resume1_dca", dca_o, 22'h07F701);
        step();
        chk("resume2_dca", dca_o, 22'h3FF000);

        // Reset with a full pipeline, taking priority over active low
        active = 1'b0;
        rst = 1'b1;
        drive(MOS8580, 12'hA00, 8'h02, WAVEFORM_DC_8580, 32'sh10, 1'b0);
        step();
        chk("rst_full_wave_amp", 22'(wave_amp), 22'h0);
        chk("rst_full_dca", dca_o, 22'h0);
        rst = 1'b0;
        active = 1'b1;
        step();
        chk("post_rst1_wave_amp", 22'(wave_amp), 22'hA00);
        chk("post_rst1_dca", dca_o, 22'h0);
        step();
        chk("post_rst2_dca", dca_o, 22'h000410);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
